// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack: op encoding and the count-width helper.
package stack_pkg;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  // Bits needed to hold values 0..n-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/stack_slot.sv
// One stack entry: WIDTH-bit register with write-enable, clear and synchronous reset.
module stack_slot #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             ctl,
  input  logic             rst,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(negedge ctl) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end else if (clr) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack with push, pop and replace-top, sticky over/underflow flags,
// and every entry exposed on a flat bus for the display path.
module param_lifo_stack
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLEAR_ON_POP = 1
) (
  input  logic                          ctl,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic [clog2(DEPTH+1)-1:0]     count,
  output logic                          empty,
  output logic                          full,
  output logic                          over,
  output logic                          under,
  output logic [DEPTH*WIDTH-1:0]        entries
);

  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [CW-1:0]    count_q, count_d;
  logic             over_q, over_d;
  logic             under_q, under_d;
  logic             wr_en, clr_en;
  logic [CW-1:0]    wr_idx, clr_idx;
  logic [DEPTH-1:0] we, clr;
  logic [WIDTH-1:0] slot_q [DEPTH];
  logic             is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  always_comb begin
    count_d = count_q;
    over_d  = over_q;
    under_d = under_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    clr_en  = 1'b0;
    clr_idx = '0;
    unique case ({push, pop})
      OP_IDLE: ;
      OP_PUSH: begin
        if (!is_full) begin
          wr_en   = 1'b1;
          wr_idx  = count_q;
          count_d = count_q + CW'(1);
          under_d = 1'b0;
        end else begin
          over_d = 1'b1;
        end
      end
      OP_POP: begin
        if (!is_empty) begin
          count_d = count_q - CW'(1);
          clr_en  = (CLEAR_ON_POP != 0);
          clr_idx = count_q - CW'(1);
          over_d  = 1'b0;
        end else begin
          under_d = 1'b1;
        end
      end
      OP_REPL: begin
        // Replace on an empty stack degenerates into a push into slot 0.
        wr_en = 1'b1;
        if (!is_empty) begin
          wr_idx = count_q - CW'(1);
        end else begin
          wr_idx  = '0;
          count_d = CW'(1);
          under_d = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    we  = '0;
    clr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      we[i]  = wr_en && (wr_idx == CW'(i));
      clr[i] = clr_en && (clr_idx == CW'(i));
    end
  end

  always_ff @(negedge ctl) begin
    if (rst) begin
      count_q <= '0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      count_q <= count_d;
      over_q  <= over_d;
      under_q <= under_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    stack_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .ctl (ctl),
      .rst (rst),
      .we  (we[i]),
      .clr (clr[i]),
      .d   (din),
      .q   (slot_q[i])
    );
    assign entries[i*WIDTH +: WIDTH] = slot_q[i];
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == CW'(i + 1)) begin
        dout = slot_q[i];
      end
    end
  end

  assign count = count_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign over  = over_q;
  assign under = under_q;

endmodule
